// File: rtl/sram_ahb_wait_fsm_pkg.sv
// rtl/sram_ahb_wait_fsm_pkg.sv - shared encodings and helpers for the SRAM AHB-Lite slave FSM
package sram_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_WRITE   = 3'b001,
      ST_WR2RD   = 3'b011,
      ST_RD_WAIT = 3'b110,
      ST_READ    = 3'b010,
      ST_ERR1    = 3'b100,
      ST_ERR2    = 3'b101
   } state_t;

   function automatic bit rd_lat_ok(input int lat);
      return (lat >= 1) && (lat <= 4);
   endfunction

endpackage

// File: rtl/sram_ahb_wait_cnt.sv
// rtl/sram_ahb_wait_cnt.sv - loadable down-counter timing SRAM read wait states
module sram_ahb_wait_cnt #(
   parameter int W = 2
) (
   input  logic         hclk,
   input  logic         hresetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/sram_ahb_wait_fsm.sv
// rtl/sram_ahb_wait_fsm.sv - AHB-Lite slave control FSM for a single-port SRAM with read wait states
module sram_ahb_wait_fsm
   import sram_ahb_pkg::*;
#(
   parameter int AW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic          hsel,
   input  logic          hready_in,
   input  logic [1:0]    htrans,
   input  logic          hwrite,
   input  logic [AW-1:0] haddr,
   input  logic          error_check,
   output logic          hready_out,
   output logic          hresp,
   output logic          sram_ce,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [2:0]    state
);

   localparam int            CW       = $clog2(RD_LAT) + 1;
   localparam bit            USE_WAIT = (RD_LAT > 1);
   localparam logic [CW-1:0] CNT_LOAD = USE_WAIT ? CW'(RD_LAT - 2) : '0;

   if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
      $error("sram_ahb_wait_fsm: RD_LAT must be 1..4");
   end

   state_t        st;
   state_t        nxt;
   state_t        rd_next;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          hready_r;
   logic          hresp_r;
   logic          data_rdy;
   logic          open_st;
   logic          accept;
   logic          acc_err;
   logic          acc_wr;
   logic          acc_rd;
   logic          cnt_load;
   logic          cnt_dec;
   logic          cnt_done;

   // Address phases are only sampled while this slave is completing a data phase.
   assign data_rdy = (st == ST_IDLE) || (st == ST_WRITE) || (st == ST_READ) || (st == ST_ERR2);
   assign open_st  = (st == ST_IDLE) || (st == ST_READ)  || (st == ST_ERR2);
   assign accept   = hsel & hready_in & htrans[1] & data_rdy;
   assign acc_err  = accept & error_check;
   assign acc_wr   = accept & ~error_check & hwrite;
   assign acc_rd   = accept & ~error_check & ~hwrite;
   assign rd_next  = USE_WAIT ? ST_RD_WAIT : ST_READ;

   assign cnt_load = USE_WAIT & ((open_st & acc_rd) | (st == ST_WR2RD));
   assign cnt_dec  = (st == ST_RD_WAIT);

   sram_ahb_wait_cnt #(.W(CW)) u_wait_cnt (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .load     (cnt_load),
      .load_val (CNT_LOAD),
      .dec      (cnt_dec),
      .done     (cnt_done)
   );

   always_comb begin
      nxt = ST_IDLE;
      case (st)
         ST_IDLE, ST_READ, ST_ERR2: begin
            if (acc_err)     nxt = ST_ERR1;
            else if (acc_wr) nxt = ST_WRITE;
            else if (acc_rd) nxt = rd_next;
            else             nxt = ST_IDLE;
         end
         ST_WRITE: begin
            if (acc_err)     nxt = ST_ERR1;
            else if (acc_wr) nxt = ST_WRITE;
            else if (acc_rd) nxt = ST_WR2RD;
            else             nxt = ST_IDLE;
         end
         ST_WR2RD:   nxt = rd_next;
         ST_RD_WAIT: nxt = cnt_done ? ST_READ : ST_RD_WAIT;
         ST_ERR1:    nxt = ST_ERR2;
         default:    nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         st       <= ST_IDLE;
         hready_r <= 1'b1;
         hresp_r  <= 1'b0;
         wr_addr  <= '0;
         rd_addr  <= '0;
      end else begin
         st       <= nxt;
         hready_r <= !((nxt == ST_WR2RD) || (nxt == ST_RD_WAIT) || (nxt == ST_ERR1));
         hresp_r  <= (nxt == ST_ERR1) || (nxt == ST_ERR2);
         if (acc_wr)
            wr_addr <= haddr;
         // A read arriving behind a write must wait for the port; hold its address.
         if ((st == ST_WRITE) && acc_rd)
            rd_addr <= haddr;
      end
   end

   always_comb begin
      sram_ce   = 1'b0;
      sram_we   = 1'b0;
      sram_addr = '0;
      if (hresetn) begin
         case (st)
            ST_IDLE, ST_READ, ST_ERR2: begin
               if (acc_rd) begin
                  sram_ce   = 1'b1;
                  sram_addr = haddr;
               end
            end
            ST_WRITE: begin
               sram_ce   = 1'b1;
               sram_we   = 1'b1;
               sram_addr = wr_addr;
            end
            ST_WR2RD: begin
               sram_ce   = 1'b1;
               sram_addr = rd_addr;
            end
            default: ;
         endcase
      end
   end

   assign hready_out = hready_r;
   assign hresp      = hresp_r;
   assign state      = st;

endmodule

// File: tb/tb_sram_ahb_wait_fsm.sv
// tb/tb_sram_ahb_wait_fsm.sv - directed vector bench for sram_ahb_wait_fsm at RD_LAT=1 and RD_LAT=3
module tb_sram_ahb_wait_fsm;
   import sram_ahb_pkg::*;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel;
   logic        hready_in;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [15:0] haddr;
   logic        error_check;

   logic        a_rdy, a_resp, a_ce, a_we;
   logic [15:0] a_addr;
   logic [2:0]  a_st;
   logic        b_rdy, b_resp, b_ce, b_we;
   logic [15:0] b_addr;
   logic [2:0]  b_st;

   int total = 0;
   int bad   = 0;

   always #5 hclk = ~hclk;

   sram_ahb_wait_fsm #(.AW(16), .RD_LAT(1)) dut_a (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hready_in(hready_in),
      .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .error_check(error_check),
      .hready_out(a_rdy), .hresp(a_resp), .sram_ce(a_ce), .sram_we(a_we),
      .sram_addr(a_addr), .state(a_st)
   );

   sram_ahb_wait_fsm #(.AW(16), .RD_LAT(3)) dut_b (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hready_in(hready_in),
      .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .error_check(error_check),
      .hready_out(b_rdy), .hresp(b_resp), .sram_ce(b_ce), .sram_we(b_we),
      .sram_addr(b_addr), .state(b_st)
   );

   typedef struct {
      logic        sel;
      logic        rin;
      logic [1:0]  tr;
      logic        wr;
      logic [15:0] ad;
      logic        er;
      logic [2:0]  e_st;
      logic        e_rdy;
      logic        e_resp;
      logic        e_ce;
      logic        e_we;
      logic [15:0] e_ad;
   } vec_t;

   vec_t vt[19];

   function automatic vec_t mk(logic sel, logic rin, logic [1:0] tr, logic wr, logic [15:0] ad,
                               logic er, logic [2:0] st, logic rdy, logic resp, logic ce,
                               logic we, logic [15:0] ead);
      vec_t v;
      v.sel = sel; v.rin = rin; v.tr = tr; v.wr = wr; v.ad = ad; v.er = er;
      v.e_st = st; v.e_rdy = rdy; v.e_resp = resp; v.e_ce = ce; v.e_we = we; v.e_ad = ead;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic sel, input logic rin, input logic [1:0] tr,
                        input logic wr, input logic [15:0] ad, input logic er);
      hsel = sel; hready_in = rin; htrans = tr; hwrite = wr; haddr = ad; error_check = er;
   endtask

   task automatic chk_b(input string tag, input int st, input int rdy, input int ce);
      chk({tag, ".state"}, b_st, st);
      chk({tag, ".hready"}, b_rdy, rdy);
      chk({tag, ".ce"}, b_ce, ce);
   endtask

   initial begin
      int ce_pulses;
      int wst[3];
      int wrdy[3];

      //          sel rin tr     wr ad     er  st rdy rsp ce we ad
      vt[0]  = mk(0, 1, 2'b00, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000);
      vt[1]  = mk(1, 1, 2'b10, 1, 16'h0010, 0, 0, 1, 0, 0, 0, 16'h0000);
      vt[2]  = mk(1, 1, 2'b11, 1, 16'h0014, 0, 1, 1, 0, 1, 1, 16'h0010);
      vt[3]  = mk(1, 1, 2'b00, 0, 16'h0000, 0, 1, 1, 0, 1, 1, 16'h0014);
      vt[4]  = mk(1, 1, 2'b00, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000);
      vt[5]  = mk(1, 1, 2'b10, 0, 16'h0020, 0, 0, 1, 0, 1, 0, 16'h0020);
      vt[6]  = mk(1, 1, 2'b11, 0, 16'h0024, 0, 2, 1, 0, 1, 0, 16'h0024);
      vt[7]  = mk(1, 1, 2'b01, 0, 16'h0028, 0, 2, 1, 0, 0, 0, 16'h0000);
      vt[8]  = mk(1, 1, 2'b11, 0, 16'h0028, 0, 0, 1, 0, 1, 0, 16'h0028);
      vt[9]  = mk(1, 1, 2'b10, 1, 16'h0030, 0, 2, 1, 0, 0, 0, 16'h0000);
      vt[10] = mk(1, 1, 2'b10, 0, 16'h0040, 0, 1, 1, 0, 1, 1, 16'h0030);
      vt[11] = mk(1, 0, 2'b00, 0, 16'h0000, 0, 3, 0, 0, 1, 0, 16'h0040);
      vt[12] = mk(1, 1, 2'b00, 0, 16'h0000, 0, 2, 1, 0, 0, 0, 16'h0000);
      vt[13] = mk(1, 1, 2'b10, 0, 16'h0050, 1, 0, 1, 0, 0, 0, 16'h0000);
      vt[14] = mk(1, 0, 2'b00, 0, 16'h0000, 0, 4, 0, 1, 0, 0, 16'h0000);
      vt[15] = mk(1, 1, 2'b10, 1, 16'h0070, 0, 5, 1, 1, 0, 0, 16'h0000);
      vt[16] = mk(0, 1, 2'b10, 0, 16'h0060, 0, 1, 1, 0, 1, 1, 16'h0070);
      vt[17] = mk(1, 0, 2'b10, 0, 16'h0060, 0, 0, 1, 0, 0, 0, 16'h0000);
      vt[18] = mk(1, 1, 2'b01, 0, 16'h0060, 0, 0, 1, 0, 0, 0, 16'h0000);

      hresetn = 1'b0;
      drive(0, 1, HTRANS_IDLE, 0, 16'h0, 0);
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      hresetn = 1'b1;

      for (int i = 0; i < 19; i++) begin
         drive(vt[i].sel, vt[i].rin, vt[i].tr, vt[i].wr, vt[i].ad, vt[i].er);
         #1;
         chk($sformatf("v%0d.state", i), a_st, vt[i].e_st);
         chk($sformatf("v%0d.hready", i), a_rdy, vt[i].e_rdy);
         chk($sformatf("v%0d.hresp", i), a_resp, vt[i].e_resp);
         chk($sformatf("v%0d.ce", i), a_ce, vt[i].e_ce);
         chk($sformatf("v%0d.we", i), a_we, vt[i].e_we);
         chk($sformatf("v%0d.addr", i), a_addr, vt[i].e_ad);
         @(negedge hclk);
      end

      drive(1, 1, HTRANS_IDLE, 0, 16'h0, 0);
      repeat (4) @(negedge hclk);

      // RD_LAT=3 plain read: hready low two cycles, one sram_ce pulse
      wst  = '{6, 6, 2};
      wrdy = '{0, 0, 1};
      drive(1, 1, HTRANS_NONSEQ, 0, 16'h0020, 0);
      #1;
      chk("rd3.issue_state", b_st, 0);
      chk("rd3.issue_ce", b_ce, 1);
      chk("rd3.issue_addr", b_addr, 16'h0020);
      ce_pulses = int'(b_ce);
      @(negedge hclk);
      drive(1, 1, HTRANS_IDLE, 0, 16'h0, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_b($sformatf("rd3.c%0d", k + 1), wst[k], wrdy[k], 0);
         ce_pulses += int'(b_ce);
         @(negedge hclk);
      end
      chk("rd3.ce_pulses", ce_pulses, 1);

      // RD_LAT=3 write then read: extra turnaround cycle
      drive(1, 1, HTRANS_NONSEQ, 1, 16'h0030, 0);
      @(negedge hclk);
      drive(1, 1, HTRANS_NONSEQ, 0, 16'h0040, 0);
      #1;
      chk("wr2rd3.w_state", b_st, 1);
      chk("wr2rd3.w_we", b_we, 1);
      chk("wr2rd3.w_addr", b_addr, 16'h0030);
      @(negedge hclk);
      drive(1, 1, HTRANS_IDLE, 0, 16'h0, 0);
      #1;
      chk_b("wr2rd3.t", 3, 0, 1);
      chk("wr2rd3.t_we", b_we, 0);
      chk("wr2rd3.t_addr", b_addr, 16'h0040);
      @(negedge hclk);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_b($sformatf("wr2rd3.c%0d", k + 1), wst[k], wrdy[k], 0);
         @(negedge hclk);
      end

      // Reset asserted while RD_WAIT: aborts at once, no strobe during reset
      drive(1, 1, HTRANS_NONSEQ, 0, 16'h0020, 0);
      @(negedge hclk);
      #1;
      chk("rst.pre_state", b_st, 6);
      #1;
      hresetn = 1'b0;
      #1;
      chk_b("rst.during", 0, 1, 0);
      chk("rst.during_a_ce", a_ce, 0);
      @(negedge hclk);
      hresetn = 1'b1;
      drive(1, 1, HTRANS_IDLE, 0, 16'h0, 0);
      #1;
      chk_b("rst.after", 0, 1, 0);
      chk("rst.after_hresp", b_resp, 0);
      @(negedge hclk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
